// File: rtl/topo2a_ad_proj_pkg.sv
`default_nettype none
// ============================================================================
// Module : topo2a_ad_proj_pkg
// Brief  : Shared constants for the lane-parallel signed multiply pipeline.
// Rev    : 1.0 - initial release
// ============================================================================
package topo2a_ad_proj_pkg;

  localparam int SAT_MODE_WRAP = 0;
  localparam int SAT_MODE_SAT  = 1;
  localparam int SAT_CNT_W     = 16;

endpackage
`default_nettype wire

// File: rtl/topo2a_ad_proj_mul_lane.sv
`default_nettype none
// ============================================================================
// Module : topo2a_ad_proj_mul_lane
// Brief  : One lane: full-width signed multiply, arithmetic shift, range
//          check / saturation, then NUM_STAGE result registers.
// Rev    : 1.0 - initial release
// ============================================================================
module topo2a_ad_proj_mul_lane
  import topo2a_ad_proj_pkg::*;
#(
  parameter int din0_WIDTH = 19,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 23,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0,
  parameter int SAT_MODE   = SAT_MODE_SAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_advance,
  input  logic [din0_WIDTH-1:0] i_din0,
  input  logic [din1_WIDTH-1:0] i_din1,
  output logic [dout_WIDTH-1:0] o_dout,
  output logic                  o_ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;

  logic signed [PW-1:0]  w_a;
  logic signed [PW-1:0]  w_b;
  logic signed [PW-1:0]  w_prod;
  logic signed [PW-1:0]  w_shift;
  logic [dout_WIDTH-1:0] w_dout;
  logic                  w_ovf;

  // Operands are sign-extended to the product width so the PW-bit product is exact.
  assign w_a     = {{din1_WIDTH{i_din0[din0_WIDTH-1]}}, i_din0};
  assign w_b     = {{din0_WIDTH{i_din1[din1_WIDTH-1]}}, i_din1};
  assign w_prod  = w_a * w_b;
  assign w_shift = w_prod >>> SHIFT;

  generate
    if (dout_WIDTH > PW) begin : g_wide
      assign w_dout = {{(dout_WIDTH - PW){w_shift[PW-1]}}, w_shift};
      assign w_ovf  = 1'b0;
    end else begin : g_narrow
      // In range iff every bit from the result sign bit upward is identical.
      logic [PW-dout_WIDTH:0] w_hi;
      assign w_hi  = w_shift[PW-1:dout_WIDTH-1];
      assign w_ovf = ~((&w_hi) | (~|w_hi));

      always_comb begin
        w_dout = w_shift[dout_WIDTH-1:0];
        if (w_ovf && (SAT_MODE == SAT_MODE_SAT)) begin
          w_dout = w_shift[PW-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                 : {1'b0, {(dout_WIDTH-1){1'b1}}};
        end
      end
    end
  endgenerate

  logic [dout_WIDTH-1:0] r_dout [NUM_STAGE];
  logic [NUM_STAGE-1:0]  r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STAGE; s++) r_dout[s] <= '0;
      r_ovf <= '0;
    end else if (i_advance) begin
      r_dout[0] <= w_dout;
      r_ovf[0]  <= w_ovf;
      for (int s = 1; s < NUM_STAGE; s++) begin
        r_dout[s] <= r_dout[s-1];
        r_ovf[s]  <= r_ovf[s-1];
      end
    end
  end

  assign o_dout = r_dout[NUM_STAGE-1];
  assign o_ovf  = r_ovf[NUM_STAGE-1];

endmodule
`default_nettype wire

// File: rtl/topo2a_ad_proj_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module : topo2a_ad_proj_mul_pipe
// Brief  : LANES-wide signed multiply pipeline with valid/ready flow control,
//          per-lane overflow flags and a saturating overflow-bundle counter.
// Rev    : 1.0 - initial release
// ============================================================================
module topo2a_ad_proj_mul_pipe
  import topo2a_ad_proj_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int din0_WIDTH = 19,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 23,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0,
  parameter int SAT_MODE   = SAT_MODE_SAT
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*din0_WIDTH-1:0] din0,
  input  logic [LANES*din1_WIDTH-1:0] din1,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*dout_WIDTH-1:0] dout,
  output logic [LANES-1:0]            ovf,
  input  logic                        sat_cnt_clr,
  output logic [SAT_CNT_W-1:0]        sat_cnt
);

  logic                 w_advance;
  logic                 w_sat_inc;
  logic [NUM_STAGE-1:0] r_vld;
  logic [SAT_CNT_W-1:0] r_sat_cnt;

  // Whole pipeline moves in lock-step; it only stalls when the output is held.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_vld[NUM_STAGE-1];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_vld <= '0;
    end else if (w_advance) begin
      r_vld[0] <= in_valid;
      for (int s = 1; s < NUM_STAGE; s++) r_vld[s] <= r_vld[s-1];
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      topo2a_ad_proj_mul_lane #(
        .din0_WIDTH (din0_WIDTH),
        .din1_WIDTH (din1_WIDTH),
        .dout_WIDTH (dout_WIDTH),
        .NUM_STAGE  (NUM_STAGE),
        .SHIFT      (SHIFT),
        .SAT_MODE   (SAT_MODE)
      ) u_lane (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .i_advance (w_advance),
        .i_din0    (din0[l*din0_WIDTH +: din0_WIDTH]),
        .i_din1    (din1[l*din1_WIDTH +: din1_WIDTH]),
        .o_dout    (dout[l*dout_WIDTH +: dout_WIDTH]),
        .o_ovf     (ovf[l])
      );
    end
  endgenerate

  assign w_sat_inc = out_valid && out_ready && (|ovf);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      r_sat_cnt <= '0;
    end else if (w_sat_inc && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + 1'b1;
    end
  end

  assign sat_cnt = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_topo2a_ad_proj_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_topo2a_ad_proj_mul_pipe
// Brief  : Three configurations (default, wrap, SHIFT=4) driven in parallel
//          and checked against an arithmetic reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_topo2a_ad_proj_mul_pipe;

  localparam int LANES = 4;
  localparam int W0    = 19;
  localparam int W1    = 6;
  localparam int DW    = 23;
  localparam int NCFG  = 3;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic sat_cnt_clr = 1'b0;
  logic [LANES*W0-1:0] din0 = '0;
  logic [LANES*W1-1:0] din1 = '0;

  logic [NCFG-1:0]       in_ready_a;
  logic [NCFG-1:0]       out_valid_a;
  logic [LANES*DW-1:0]   dout_a [NCFG];
  logic [LANES-1:0]      ovf_a  [NCFG];
  logic [15:0]           sc_a   [NCFG];

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [LANES*W0-1:0] q0 [$];
  logic [LANES*W1-1:0] q1 [$];
  logic [15:0]         m_sat [NCFG];

  topo2a_ad_proj_mul_pipe #(.LANES(LANES), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(DW),
    .NUM_STAGE(2), .SHIFT(0), .SAT_MODE(1)) dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .din0(din0), .din1(din1), .out_valid(out_valid_a[0]), .out_ready(out_ready),
    .dout(dout_a[0]), .ovf(ovf_a[0]), .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sc_a[0]));

  topo2a_ad_proj_mul_pipe #(.LANES(LANES), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(DW),
    .NUM_STAGE(2), .SHIFT(0), .SAT_MODE(0)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .din0(din0), .din1(din1), .out_valid(out_valid_a[1]), .out_ready(out_ready),
    .dout(dout_a[1]), .ovf(ovf_a[1]), .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sc_a[1]));

  topo2a_ad_proj_mul_pipe #(.LANES(LANES), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(DW),
    .NUM_STAGE(2), .SHIFT(4), .SAT_MODE(1)) dut2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_a[2]),
    .din0(din0), .din1(din1), .out_valid(out_valid_a[2]), .out_ready(out_ready),
    .dout(dout_a[2]), .ovf(ovf_a[2]), .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sc_a[2]));

  always #5 ap_clk = ~ap_clk;

  function automatic int cfg_sh(input int k);
    return (k == 2) ? 4 : 0;
  endfunction

  function automatic bit cfg_sat(input int k);
    return (k != 1);
  endfunction

  // Reference: exact integer product, floor shift, then range check.
  function automatic logic [DW:0] model(input longint a, input longint b, input int sh, input bit sat);
    longint p, lo, hi;
    logic [DW-1:0] d;
    logic o;
    p  = (a * b) >>> sh;
    lo = -(longint'(1) <<< (DW-1));
    hi = (longint'(1) <<< (DW-1)) - 1;
    o  = (p < lo) || (p > hi);
    if (o && sat) d = (p < lo) ? DW'(lo) : DW'(hi);
    else          d = DW'(p);
    return {o, d};
  endfunction

  function automatic longint la(input logic [LANES*W0-1:0] v, input int l);
    logic signed [W0-1:0] t;
    t = v[l*W0 +: W0];
    return longint'(t);
  endfunction

  function automatic longint lb(input logic [LANES*W1-1:0] v, input int l);
    logic signed [W1-1:0] t;
    t = v[l*W1 +: W1];
    return longint'(t);
  endfunction

  function automatic logic [LANES*W0-1:0] rep0(input int v);
    logic [LANES*W0-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*W0 +: W0] = W0'(v);
    return r;
  endfunction

  function automatic logic [LANES*W1-1:0] rep1(input int v);
    logic [LANES*W1-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*W1 +: W1] = W1'(v);
    return r;
  endfunction

  function automatic logic [LANES*W0-1:0] rnd0();
    logic [LANES*W0-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[l*W0 +: W0] = ($urandom_range(0, 7) == 0) ? W0'(19'h40000) : W0'($urandom);
    return r;
  endfunction

  function automatic logic [LANES*W1-1:0] rnd1();
    logic [LANES*W1-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[l*W1 +: W1] = ($urandom_range(0, 7) == 0) ? W1'(6'h20) : W1'($urandom);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check the pending output transfer against
  // the oldest queued bundle, record the pending input acceptance.
  task automatic cyc(input bit iv, input bit ordy, input bit clr,
                     input logic [LANES*W0-1:0] a, input logic [LANES*W1-1:0] b);
    logic [LANES*W0-1:0] ea;
    logic [LANES*W1-1:0] eb;
    logic [DW:0] r;
    logic [NCFG-1:0] anyo;
    bit xfer;
    @(negedge ap_clk);
    in_valid = iv; out_ready = ordy; sat_cnt_clr = clr; din0 = a; din1 = b;
    #1;
    anyo = '0;
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("sat_cnt c%0d", k), sc_a[k], m_sat[k]);
      chk($sformatf("in_ready rule c%0d", k), in_ready_a[k], !out_valid_a[k] || ordy);
    end
    xfer = out_valid_a[0] && out_ready;
    if (xfer) begin
      chk("output has a queued bundle", q0.size() > 0, 1'b1);
      if (q0.size() > 0) begin
        ea = q0.pop_front();
        eb = q1.pop_front();
        n_out++;
        for (int k = 0; k < NCFG; k++) begin
          for (int l = 0; l < LANES; l++) begin
            r = model(la(ea, l), lb(eb, l), cfg_sh(k), cfg_sat(k));
            chk($sformatf("dout c%0d l%0d", k, l), dout_a[k][l*DW +: DW], r[DW-1:0]);
            chk($sformatf("ovf c%0d l%0d", k, l), ovf_a[k][l], r[DW]);
            anyo[k] = anyo[k] | r[DW];
          end
        end
      end
    end
    if (in_valid && in_ready_a[0]) begin
      q0.push_back(din0);
      q1.push_back(din1);
    end
    for (int k = 0; k < NCFG; k++) begin
      if (clr) m_sat[k] = '0;
      else if (xfer && anyo[k] && m_sat[k] != 16'hFFFF) m_sat[k] = m_sat[k] + 16'd1;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LANES*DW-1:0] held;
    int start, guard;
    for (int k = 0; k < NCFG; k++) m_sat[k] = '0;

    // Reset state
    #2 ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    for (int k = 0; k < NCFG; k++) begin
      chk("reset out_valid", out_valid_a[k], 1'b0);
      chk("reset in_ready", in_ready_a[k], 1'b1);
      chk("reset dout", dout_a[k], '0);
      chk("reset ovf", ovf_a[k], '0);
      chk("reset sat_cnt", sc_a[k], '0);
    end
    @(negedge ap_clk) ap_rst_n = 1'b1;

    // 1000 * -7, latency of exactly two cycles
    cyc(1, 1, 0, rep0(1000), rep1(-7));
    cyc(0, 1, 0, rep0(0), rep1(0));
    chk("latency 1 cycle out_valid", out_valid_a[0], 1'b0);
    cyc(0, 1, 0, rep0(0), rep1(0));
    chk("latency 2 cycle out_valid", out_valid_a[0], 1'b1);
    for (int l = 0; l < LANES; l++) chk("dout -7000", dout_a[0][l*DW +: DW], 23'h7FE4A8);
    chk("ovf -7000", ovf_a[0], 4'h0);

    // Most positive overflow: saturate vs wrap
    cyc(1, 1, 0, rep0(-262144), rep1(-32));
    cyc(0, 1, 0, rep0(0), rep1(0));
    cyc(0, 1, 0, rep0(0), rep1(0));
    for (int l = 0; l < LANES; l++) begin
      chk("sat dout max", dout_a[0][l*DW +: DW], 23'd4194303);
      chk("wrap dout zero", dout_a[1][l*DW +: DW], 23'd0);
    end
    chk("sat ovf", ovf_a[0], 4'hF);
    chk("wrap ovf", ovf_a[1], 4'hF);
    cyc(0, 1, 0, rep0(0), rep1(0));
    chk("sat_cnt one", sc_a[0], 16'd1);

    // Clear, then clear coinciding with an overflow transfer
    cyc(0, 1, 1, rep0(0), rep1(0));
    cyc(1, 1, 0, rep0(-262144), rep1(-32));
    chk("sat_cnt cleared", sc_a[0], 16'd0);
    cyc(0, 1, 0, rep0(0), rep1(0));
    cyc(0, 1, 1, rep0(0), rep1(0));
    cyc(0, 1, 0, rep0(0), rep1(0));
    chk("clear wins over increment", sc_a[0], 16'd0);

    // SHIFT=4 floors -1 to -1
    cyc(1, 1, 0, rep0(-1), rep1(1));
    cyc(0, 1, 0, rep0(0), rep1(0));
    cyc(0, 1, 0, rep0(0), rep1(0));
    for (int l = 0; l < LANES; l++) chk("shift floor -1", dout_a[2][l*DW +: DW], 23'h7FFFFF);
    chk("shift ovf", ovf_a[2], 4'h0);

    // Stall with a full pipeline, then drain in order
    repeat (3) cyc(1, 0, 0, rnd0(), rnd1());
    held = dout_a[0];
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, rnd0(), rnd1());
      chk("stall in_ready low", in_ready_a[0], 1'b0);
      chk("stall dout stable", dout_a[0], held);
    end
    guard = 0;
    while (q0.size() > 0 && guard < 10) begin
      cyc(0, 1, 0, rnd0(), rnd1());
      guard++;
    end
    chk("stall drained", q0.size(), 0);

    // Random traffic
    start = n_out;
    guard = 0;
    while ((n_out - start) < 10000 && guard < 60000) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
          rnd0(), rnd1());
      guard++;
    end
    chk("random bundle count reached", (n_out - start) >= 10000, 1'b1);
    guard = 0;
    while (q0.size() > 0 && guard < 20) begin
      cyc(0, 1, 0, rnd0(), rnd1());
      guard++;
    end
    chk("random drained", q0.size(), 0);

    // Reset with two bundles in flight
    cyc(1, 1, 0, rep0(-262144), rep1(-32));
    cyc(0, 1, 0, rep0(0), rep1(0));
    cyc(0, 1, 0, rep0(0), rep1(0));
    cyc(1, 0, 0, rnd0(), rnd1());
    cyc(1, 0, 0, rnd0(), rnd1());
    @(negedge ap_clk);
    in_valid = 1'b0; ap_rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid_a[0], 1'b0);
    chk("midrst sat_cnt", sc_a[0], 16'd0);
    chk("midrst in_ready", in_ready_a[0], 1'b1);
    chk("midrst dout", dout_a[0], '0);
    q0.delete();
    q1.delete();
    for (int k = 0; k < NCFG; k++) m_sat[k] = '0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, rnd0(), rnd1());
      chk("no stale bundle", out_valid_a[0], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/topo2a_ad_proj_mul_pipe.md
TOPO2A_AD_PROJ_MUL_PIPE -- requirements
Module: topo2a_ad_proj_mul_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent multiply lanes.
REQ-002 SHALL have parameter din0_WIDTH, default 19, signed multiplicand width per lane.
REQ-003 SHALL have parameter din1_WIDTH, default 6, signed multiplier width per lane.
REQ-004 SHALL have parameter dout_WIDTH, default 23, signed result width per lane.
REQ-005 SHALL have parameter NUM_STAGE, default 2, pipeline latency in cycles, legal range 1..4.
REQ-006 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to the full product, range 0..din0_WIDTH+din1_WIDTH-1.
REQ-007 SHALL have parameter SAT_MODE, default 1: 0 = wrap (truncate), 1 = saturate to dout_WIDTH signed range.
REQ-008 SHALL have ap_clk  input  1  single clock, rising edge.
REQ-009 SHALL have ap_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-010 SHALL have in_valid  input  1  operand bundle valid.
REQ-011 SHALL have in_ready  output  1  block accepts a bundle this cycle.
REQ-012 SHALL have din0  input  LANES*din0_WIDTH  packed signed operands, lane 0 in LSBs.
REQ-013 SHALL have din1  input  LANES*din1_WIDTH  packed signed operands, lane 0 in LSBs.
REQ-014 SHALL have out_valid  output  1  result bundle valid.
REQ-015 SHALL have out_ready  input  1  downstream accepts result.
REQ-016 SHALL have dout  output  LANES*dout_WIDTH  packed signed results, lane 0 in LSBs.
REQ-017 SHALL have ovf  output  LANES  per-lane flag, product exceeded dout range, aligned with dout.
REQ-018 SHALL have sat_cnt_clr  input  1  synchronous clear of sat_cnt.
REQ-019 SHALL have sat_cnt  output  16  count of accepted result bundles with any ovf bit set, saturating at 0xFFFF.

Function
REQ-020 SHALL compute per lane p = signed(din0_i) * signed(din1_i) at full width din0_WIDTH+din1_WIDTH, then p >>> SHIFT (arithmetic, floor).
REQ-021 SHALL set ovf_i when shifted p lies outside [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]; with SAT_MODE=1 dout_i SHALL clamp to the bound, with SAT_MODE=0 dout_i SHALL be the low dout_WIDTH bits.
REQ-022 SHALL, when dout_WIDTH exceeds shifted-product width, sign-extend and never assert ovf.
REQ-023 SHALL transfer input when in_valid && in_ready, output when out_valid && out_ready.
REQ-024 SHALL drive in_ready = !out_valid || out_ready (global pipeline advance signal, combinational, no dependency on in_valid).
REQ-025 SHALL hold every stage register, valid bit, dout and ovf stable while advance is low.
REQ-026 SHALL, with continuous in_valid and out_ready high, present result of bundle n exactly NUM_STAGE cycles after its acceptance, one bundle per cycle, no bubbles.
REQ-027 SHALL propagate bubbles: a stage advanced with invalid input SHALL clear its valid bit; data registers of invalid stages are don't-care but SHALL not raise out_valid.
REQ-028 SHALL increment sat_cnt on each output transfer with |ovf, saturating at 0xFFFF; sat_cnt_clr SHALL zero it and, if simultaneous with an increment, clear wins.
REQ-029 SHALL not drop, duplicate or reorder bundles under any in_valid/out_ready pattern.

Reset
REQ-030 SHALL, on ap_rst_n low, asynchronously clear all stage valid bits, out_valid=0, dout=0, ovf=0, sat_cnt=0.
REQ-031 SHALL discard in-flight bundles on reset mid-operation; first post-reset acceptance SHALL occur no earlier than the first rising edge with ap_rst_n high.
REQ-032 SHALL drive in_ready=1 during and after reset (pipeline empty).

Structure
REQ-033 SHALL place SAT_MODE encodings and sat_cnt width constant in shared package topo2a_ad_proj_pkg.
REQ-034 SHALL instantiate one sub-module per lane, topo2a_ad_proj_mul_lane (multiply, shift, saturate, ovf), with valid/advance control shared in the top.

Verification
REQ-035 SHALL cover defaults, din0=1000, din1=-7, out_ready=1 -> dout lane=-7000, ovf=0, out_valid exactly 2 cycles after accept.
REQ-036 SHALL cover SAT_MODE=1, din0=-262144, din1=-32 -> dout=4194303, ovf=1, sat_cnt=1; SAT_MODE=0 same -> dout=0, ovf=1.
REQ-037 SHALL cover SHIFT=4, din0=-1, din1=1 -> dout=-1 (floor), ovf=0.
REQ-038 SHALL cover random in_valid/out_ready (50% each), 10000 bundles -> outputs match in-order golden model, no loss.
REQ-039 SHALL cover out_ready=0 for 5 cycles with full pipeline -> in_ready=0, dout stable; release -> bundles drain in order.
REQ-040 SHALL cover ap_rst_n pulse with 2 bundles in flight -> out_valid=0 immediately, sat_cnt=0, no stale bundle emitted afterward.
